// File: rtl/ncl_mash_n.sv
// Noise-cancellation network for an N-stage MASH 1-1-...-1 DDSM: Y = sum (1-z^-1)^(k-1) y_k.
// Define NCL_PIPE_EN for a per-stage pipelined chain with a fill counter gating valid_o.
module ncl_mash_n #(
    parameter int unsigned STAGES  = 3,
    parameter int unsigned OUT_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          valid_i,
    input  logic [$clog2(STAGES+1)-1:0]   order_i,
    input  logic [STAGES-1:0]             y_i,
    output logic signed [STAGES:0]        y_o,
    output logic                          valid_o
);

    localparam int unsigned OW = STAGES + 1;
    localparam int unsigned HN = (STAGES > 1) ? STAGES - 1 : 1;

    typedef logic signed [OW-1:0] sw_t;

    function automatic sw_t bext(input logic b);
        return sw_t'({{(OW-1){1'b0}}, b});
    endfunction

    logic              acc;
    logic              stage_valid;
    logic [STAGES-1:0] ym;
    sw_t               stage_c [STAGES:1];
    sw_t               hist_q  [HN:1];
    sw_t               hist_d  [HN:1];

    assign acc = valid_i & ~clr_i;

    // Order mask: stages above the effective order contribute nothing.
    always_comb begin
        int m;
        m = int'(order_i);
        if (m == 0 || m > int'(STAGES)) m = int'(STAGES);
        for (int k = 0; k < int'(STAGES); k++) ym[k] = y_i[k] & (k < m);
    end

`ifdef NCL_PIPE_EN
    localparam int unsigned CW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CW-1:0] FILL = CW'(STAGES - 1);

    sw_t               pc_q [HN:1];
    sw_t               pc_d [HN:1];
    logic [STAGES-1:0] yd_q [HN:1];
    logic [STAGES-1:0] yd_d [HN:1];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full;

    assign full        = (cnt_q == FILL);
    assign stage_valid = acc & full;

    // pc_q[k] holds c_{k+1} one accepted sample old; yd_q[d] is the masked input d samples old.
    always_comb begin
        stage_c[STAGES] = bext(ym[STAGES-1]);
        for (int k = int'(STAGES) - 1; k >= 1; k--) begin
            stage_c[k] = bext(yd_q[int'(STAGES) - k][k-1]) + pc_q[k] - hist_q[k];
        end
        for (int k = 1; k <= int'(HN); k++) begin
            pc_d[k]   = clr_i ? '0 : (valid_i ? stage_c[k+1] : pc_q[k]);
            hist_d[k] = clr_i ? '0 : (valid_i ? pc_q[k]      : hist_q[k]);
        end
        yd_d[1] = clr_i ? '0 : (valid_i ? ym : yd_q[1]);
        for (int k = 2; k <= int'(HN); k++) begin
            yd_d[k] = clr_i ? '0 : (valid_i ? yd_q[k-1] : yd_q[k]);
        end
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else if (valid_i && !full) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '{default: '0};
            pc_q   <= '{default: '0};
            yd_q   <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pc_q   <= pc_d;
            yd_q   <= yd_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign stage_valid = acc;

    // hist_q[k] holds c_{k+1} of the previous accepted sample.
    always_comb begin
        stage_c[STAGES] = bext(ym[STAGES-1]);
        for (int k = int'(STAGES) - 1; k >= 1; k--) begin
            stage_c[k] = bext(ym[k-1]) + stage_c[k+1] - hist_q[k];
        end
        for (int k = 1; k <= int'(HN); k++) begin
            hist_d[k] = clr_i ? '0 : (valid_i ? stage_c[k+1] : hist_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= '{default: '0};
        else        hist_q <= hist_d;
    end
`endif

    generate
        if (OUT_REG != 0) begin : g_oreg
            sw_t  y_q, y_d;
            logic valid_q;

            always_comb begin
                y_d = y_q;
                if (clr_i)        y_d = '0;
                else if (valid_i) y_d = stage_c[1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    y_q     <= y_d;
                    valid_q <= stage_valid;
                end
            end

            assign y_o     = y_q;
            assign valid_o = valid_q;
        end else begin : g_comb
            assign y_o     = stage_c[1];
            assign valid_o = stage_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ncl_mash_n.sv
// Randomised self-checking bench for ncl_mash_n (STAGES=3, OUT_REG=1) against a
// binomial-expansion reference model; also honours NCL_PIPE_EN.
module tb_ncl_mash_n;

    localparam int unsigned STAGES = 3;
    localparam int unsigned OW     = STAGES + 1;
`ifdef NCL_PIPE_EN
    localparam int P = STAGES - 1;
`else
    localparam int P = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr_i;
    logic                   valid_i;
    logic [1:0]             order_i;
    logic [STAGES-1:0]      y_i;
    logic signed [OW-1:0]   y_o;
    logic                   valid_o;

    int checks   = 0;
    int failures = 0;
    int exp_y    = 0;
    int exp_v    = 0;

    logic [STAGES-1:0] hist[$];

    ncl_mash_n #(.STAGES(STAGES), .OUT_REG(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_i),
        .valid_i (valid_i),
        .order_i (order_i),
        .y_i     (y_i),
        .y_o     (y_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int binom(input int n, input int r);
        int v = 1;
        for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
        return v;
    endfunction

    function automatic logic [STAGES-1:0] mask(input int ord, input logic [STAGES-1:0] y);
        int m = (ord == 0 || ord > int'(STAGES)) ? int'(STAGES) : ord;
        logic [STAGES-1:0] r;
        for (int k = 0; k < int'(STAGES); k++) r[k] = (k < m) ? y[k] : 1'b0;
        return r;
    endfunction

    // Y(n) = sum_k sum_j (-1)^j C(k-1,j) y_k(n-j), zero history before index 0.
    function automatic int model_y(input int idx);
        int s = 0;
        logic [STAGES-1:0] v;
        for (int k = 1; k <= int'(STAGES); k++) begin
            for (int j = 0; j < k; j++) begin
                if (idx - j >= 0) begin
                    v = hist[idx-j];
                    if (v[k-1]) s += ((j % 2) ? -1 : 1) * binom(k - 1, j);
                end
            end
        end
        return s;
    endfunction

    task automatic step(input logic v, input logic c, input int ord, input logic [STAGES-1:0] y);
        int idx;
        valid_i = v;
        clr_i   = c;
        order_i = ord[1:0];
        y_i     = y;
        @(posedge clk);
        if (c) begin
            hist.delete();
            exp_v = 0;
            exp_y = 0;
        end else if (v) begin
            hist.push_back(mask(ord, y));
            idx   = hist.size() - 1 - P;
            exp_v = (idx >= 0) ? 1 : 0;
            exp_y = (idx >= 0) ? model_y(idx) : 0;
        end else begin
            exp_v = 0;
        end
        #1;
        check_eq("valid_o", int'(valid_o), exp_v);
        check_eq("y_o", int'(y_o), exp_y);
    endtask

    initial begin
        rst_n = 1'b0; clr_i = 1'b0; valid_i = 1'b0; order_i = '0; y_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid_o", int'(valid_o), 0);
        check_eq("rst_y_o", int'(y_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous all-ones: 3, 0, 1, 1, ...
        for (int i = 0; i < 6 + P; i++) step(1'b1, 1'b0, 0, 3'b111);
        check_eq("t1_steady", int'(y_o), 1);

        // MSB-only alternating: +1, -2, +2, -2
        step(1'b0, 1'b1, 0, 3'b000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3, (i % 2 == 0) ? 3'b100 : 3'b000);
        check_eq("t2_last", int'(y_o), -2);

        // Positive extreme +4 and negative extreme -3 from zero history
        step(1'b0, 1'b1, 0, 3'b000);
        step(1'b1, 1'b0, 0, 3'b100);
        step(1'b1, 1'b0, 0, 3'b000);
        step(1'b1, 1'b0, 0, 3'b111);
`ifndef NCL_PIPE_EN
        check_eq("t3_max", int'(y_o), 4);
`endif
        step(1'b0, 1'b1, 0, 3'b000);
        step(1'b1, 1'b0, 0, 3'b110);
        step(1'b1, 1'b0, 0, 3'b000);
`ifndef NCL_PIPE_EN
        check_eq("t3_min", int'(y_o), -3);
`endif

        // Gapped 1-on/2-off all-ones
        step(1'b0, 1'b1, 0, 3'b000);
        for (int i = 0; i < 6 + P; i++) begin
            step(1'b1, 1'b0, 0, 3'b111);
            step(1'b0, 1'b0, 0, 3'($urandom));
            step(1'b0, 1'b0, 0, 3'($urandom));
        end

        // Order 1: output follows y_i[0]
        step(1'b0, 1'b1, 0, 3'b000);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1, 3'($urandom));

        // Asynchronous reset mid-stream, then all-ones restarts
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid_o", int'(valid_o), 0);
        check_eq("arst_y_o", int'(y_o), 0);
        hist.delete();
        exp_y = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 + P; i++) step(1'b1, 1'b0, 0, 3'b111);

        // Random soak: gaps, order changes, occasional clear
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                 int'($urandom_range(0, 3)), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
